wave_gen: RTL

Parametrised multi-mode periodic waveform generator driving the DAC sample path.
It is the next generation of the fixed 12-bit triangle counter. It adds:
- programmable clock-enable prescaler (replaces the derived-clock divider)
- programmable step, low/high limits and four wave modes
- shadowed configuration that takes effect only at period boundaries, so the output never glitches mid-period

Everything runs on one clock domain.

---
 rtl/wave_gen_if.sv | 31 +++
 rtl/wave_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wave_gen_if.sv
// wave_gen_if: control/config inputs and sample/status outputs of the waveform generator.
// Latency: none (signal bundle only). Backpressure: none; the sample stream is free-running.
// Modports: master drives enable/cfg_*, slave (wave_gen) drives wave_out and the status pulses.
interface wave_gen_if #(
  parameter int WIDTH  = 12,
  parameter int STEP_W = 8,
  parameter int DIV_W  = 16
);
  logic              enable;
  logic              cfg_load;
  logic [1:0]        cfg_mode;
  logic [STEP_W-1:0] cfg_step;
  logic [DIV_W-1:0]  cfg_div;
  logic [WIDTH-1:0]  cfg_lo;
  logic [WIDTH-1:0]  cfg_hi;
  logic [WIDTH-1:0]  wave_out;
  logic              sample_tick;
  logic              period_start;
  logic              dir_up;
  logic              cfg_pending;

  modport master (
    output enable, cfg_load, cfg_mode, cfg_step, cfg_div, cfg_lo, cfg_hi,
    input  wave_out, sample_tick, period_start, dir_up, cfg_pending
  );

  modport slave (
    input  enable, cfg_load, cfg_mode, cfg_step, cfg_div, cfg_lo, cfg_hi,
    output wave_out, sample_tick, period_start, dir_up, cfg_pending
  );
endinterface

// File: rtl/wave_gen.sv
// wave_gen: multi-mode periodic waveform generator (triangle, saw up, square, saw down) for the DAC path.
// Latency: wave_out/sample_tick/period_start update 1 clk after the prescaler tick condition.
// Backpressure: none; enable=0 freezes prescaler and phase, new config is applied only at period starts.
// Ports: clk, rst (sync, active-high), bus (wave_gen_if.slave) carrying enable, cfg_* and the outputs.
module wave_gen #(
  parameter int WIDTH  = 12,
  parameter int STEP_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic     clk,
  input  logic     rst,
  wave_gen_if.slave bus
);
  localparam int NW = WIDTH + 1;

  // Active configuration
  logic [1:0]        r_mode;
  logic [STEP_W-1:0] r_step;
  logic [DIV_W-1:0]  r_div;
  logic [WIDTH-1:0]  r_lo;
  logic [WIDTH-1:0]  r_hi;

  // Pending (shadow) configuration
  logic [1:0]        r_p_mode;
  logic [STEP_W-1:0] r_p_step;
  logic [DIV_W-1:0]  r_p_div;
  logic [WIDTH-1:0]  r_p_lo;
  logic [WIDTH-1:0]  r_p_hi;
  logic              r_pending;

  // Engine state and registered outputs. r_eng is the triangle/saw position;
  // it differs from r_wave only in square mode, where the output is hi/lo.
  logic [DIV_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_eng;
  logic [WIDTH-1:0]  r_wave;
  logic              r_dir;
  logic              r_tick;
  logic              r_pstart;

  logic              w_tick;
  logic              w_degen;
  logic [NW-1:0]     w_step;
  logic [NW-1:0]     w_eng_x;
  logic [NW-1:0]     w_hi_x;
  logic [NW-1:0]     w_up;
  logic [NW-1:0]     w_dnlim;
  logic [WIDTH-1:0]  w_dn;
  logic [WIDTH-1:0]  w_eng_nxt;
  logic [WIDTH-1:0]  w_wave_nxt;
  logic              w_dir_nxt;
  logic              w_wrap;

  logic              w_p_degen;
  logic              w_p_down;
  logic [WIDTH-1:0]  w_s_eng;
  logic [WIDTH-1:0]  w_s_wave;
  logic              w_s_dir;
  logic              w_apply_idle;
  logic              w_apply;

  assign w_tick  = bus.enable && (r_cnt == r_div);
  assign w_degen = (r_lo >= r_hi);

  // All limit comparisons are done one bit wider so a step past hi never wraps.
  assign w_step  = (r_step == '0) ? NW'(1) : NW'(r_step);
  assign w_eng_x = {1'b0, r_eng};
  assign w_hi_x  = {1'b0, r_hi};
  assign w_up    = w_eng_x + w_step;
  assign w_dnlim = {1'b0, r_lo} + w_step;
  // Only used when r_eng >= lo+step, so it cannot underflow.
  assign w_dn    = r_eng - w_step[WIDTH-1:0];

  always_comb begin
    w_eng_nxt = r_eng;
    w_dir_nxt = r_dir;
    w_wrap    = 1'b0;
    if (w_degen) begin
      w_eng_nxt = r_lo;
      w_dir_nxt = 1'b1;
      w_wrap    = 1'b1;
    end else begin
      case (r_mode)
        2'd1: begin
          w_dir_nxt = 1'b1;
          if (w_up > w_hi_x) begin
            w_eng_nxt = r_lo;
            w_wrap    = 1'b1;
          end else begin
            w_eng_nxt = w_up[WIDTH-1:0];
          end
        end
        2'd3: begin
          w_dir_nxt = 1'b0;
          if (w_eng_x < w_dnlim) begin
            w_eng_nxt = r_hi;
            w_wrap    = 1'b1;
          end else begin
            w_eng_nxt = w_dn;
          end
        end
        default: begin
          // Triangle engine (modes 0 and 2). Both turnarounds clamp to the
          // limit, so each extreme appears for exactly one sample.
          if (r_dir) begin
            if (w_up >= w_hi_x) begin
              w_eng_nxt = r_hi;
              w_dir_nxt = 1'b0;
            end else begin
              w_eng_nxt = w_up[WIDTH-1:0];
            end
          end else begin
            if (w_eng_x <= w_dnlim) begin
              w_eng_nxt = r_lo;
              w_dir_nxt = 1'b1;
              w_wrap    = 1'b1;
            end else begin
              w_eng_nxt = w_dn;
            end
          end
        end
      endcase
    end
  end

  assign w_wave_nxt = ((r_mode == 2'd2) && !w_degen) ? (w_dir_nxt ? r_hi : r_lo) : w_eng_nxt;

  // Start point for the pending config. Square starts with the engine at lo
  // and rising, so its first output sample is hi.
  assign w_p_degen = (r_p_lo >= r_p_hi);
  assign w_p_down  = (r_p_mode == 2'd3) && !w_p_degen;
  assign w_s_eng   = w_p_down ? r_p_hi : r_p_lo;
  assign w_s_dir   = !w_p_down;
  assign w_s_wave  = ((r_p_mode == 2'd2) && !w_p_degen) ? r_p_hi : w_s_eng;

  assign w_apply_idle = !bus.enable && r_pending;
  assign w_apply      = (w_tick && w_wrap && r_pending) || w_apply_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode    <= 2'd0;
      r_step    <= STEP_W'(1);
      r_div     <= '0;
      r_lo      <= '0;
      r_hi      <= '1;
      r_p_mode  <= 2'd0;
      r_p_step  <= STEP_W'(1);
      r_p_div   <= '0;
      r_p_lo    <= '0;
      r_p_hi    <= '1;
      r_pending <= 1'b0;
      r_cnt     <= '0;
      r_eng     <= '0;
      r_wave    <= '0;
      r_dir     <= 1'b1;
      r_tick    <= 1'b0;
      r_pstart  <= 1'b0;
    end else begin
      r_tick   <= w_tick;
      r_pstart <= w_tick && w_wrap;

      if (bus.enable) begin
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      end
      if (w_apply_idle) begin
        r_cnt <= '0;
      end

      if (w_apply) begin
        r_mode <= r_p_mode;
        r_step <= r_p_step;
        r_div  <= r_p_div;
        r_lo   <= r_p_lo;
        r_hi   <= r_p_hi;
        r_eng  <= w_s_eng;
        r_dir  <= w_s_dir;
        r_wave <= w_s_wave;
      end else if (w_tick) begin
        r_eng  <= w_eng_nxt;
        r_dir  <= w_dir_nxt;
        r_wave <= w_wave_nxt;
      end

      // A load in the same cycle as an apply stays pending for the next one.
      if (bus.cfg_load) begin
        r_p_mode  <= bus.cfg_mode;
        r_p_step  <= bus.cfg_step;
        r_p_div   <= bus.cfg_div;
        r_p_lo    <= bus.cfg_lo;
        r_p_hi    <= bus.cfg_hi;
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign bus.wave_out     = r_wave;
  assign bus.sample_tick  = r_tick;
  assign bus.period_start = r_pstart;
  assign bus.dir_up       = r_dir;
  assign bus.cfg_pending  = r_pending;
endmodule
